// File: rtl/layer_seq.sv
// Layer sequencer: walks up to NL layer descriptors, driving the datapath
// through bias load, weight load and run phases, with a one-cycle gap
// between layers so downstream control can re-initialise.
// Optional build macro LAYER_SEQ_PERF_EN adds a saturating busy-cycle
// counter output cyc_cnt.
module layer_seq #(
  parameter int NL = 4,
  localparam int LW = $clog2(NL)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_we,
  input  logic [LW-1:0] cfg_layer,
  input  logic [1:0]    cfg_field,
  input  logic [31:0]   cfg_wdata,
  input  logic [LW:0]   num_layers,
  input  logic          start,
  input  logic          abort,
  input  logic          src_valid,
  input  logic          src_ready,
  input  logic          run_done,
  output logic          bwrite,
  output logic          wwrite,
  output logic          run,
  output logic [LW-1:0] layer,
  output logic [63:0]   geom,
  output logic          busy,
  output logic          done
`ifdef LAYER_SEQ_PERF_EN
  ,
  output logic [31:0]   cyc_cnt
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_BIAS, S_WGT, S_RUN, S_GAP} state_t;

  localparam logic [LW:0] NL_CNT = (LW+1)'(NL);

  // Descriptor storage
  logic [11:0] bias_mem [NL];
  logic [15:0] wgt_mem  [NL];
  logic [63:0] geom_mem [NL];

  state_t        state, state_n;
  logic [LW:0]   lay_cnt, lay_cnt_n, eff_cnt;
  logic [LW-1:0] layer_n, layer_inc;
  logic [15:0]   beat_cnt, beat_n, bias_last, wgt_last;
  logic [63:0]   geom_n;
  logic          done_n, beat, start_acc, cfg_acc;

  assign beat      = src_valid & src_ready;
  assign eff_cnt   = (num_layers > NL_CNT) ? NL_CNT : num_layers;
  assign start_acc = (state == S_IDLE) && !busy && start && (eff_cnt != '0);
  // busy also covers the done cycle, so this only opens once fully idle
  assign cfg_acc   = cfg_we && !busy && (state == S_IDLE);
  assign layer_inc = layer + LW'(1);
  assign bias_last = {4'h0, bias_mem[layer]} - 16'd1;
  assign wgt_last  = wgt_mem[layer] - 16'd1;

  // First phase of a layer skips any load whose count is zero
  function automatic state_t entry_state(input logic [11:0] b, input logic [15:0] w);
    if (b != 12'd0) return S_BIAS;
    if (w != 16'd0) return S_WGT;
    return S_RUN;
  endfunction

  // Descriptor writes, accepted only while the sequencer is idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the descriptor table is small and must read as zero after
      // reset, so it is built from resettable flops rather than a RAM.
      for (int i = 0; i < NL; i++) begin
        bias_mem[i] <= '0;
        wgt_mem[i]  <= '0;
        geom_mem[i] <= '0;
      end
    end else if (cfg_acc) begin
      case (cfg_field)
        2'd0: bias_mem[cfg_layer]        <= cfg_wdata[11:0];
        2'd1: wgt_mem[cfg_layer]         <= cfg_wdata[15:0];
        2'd2: geom_mem[cfg_layer][31:0]  <= cfg_wdata;
        2'd3: geom_mem[cfg_layer][63:32] <= cfg_wdata;
      endcase
    end
  end

  // Next-state and next-value decode for the sequencer
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_n   = state;
    layer_n   = layer;
    lay_cnt_n = lay_cnt;
    beat_n    = beat_cnt;
    geom_n    = geom;
    done_n    = 1'b0;
    case (state)
      S_IDLE: if (start_acc) begin
        state_n   = entry_state(bias_mem[0], wgt_mem[0]);
        layer_n   = '0;
        geom_n    = geom_mem[0];
        lay_cnt_n = eff_cnt;
        beat_n    = '0;
      end
      S_BIAS: if (beat) begin
        if (beat_cnt == bias_last) begin
          beat_n  = '0;
          state_n = (wgt_mem[layer] != 16'd0) ? S_WGT : S_RUN;
        end else begin
          beat_n = beat_cnt + 16'd1;
        end
      end
      S_WGT: if (beat) begin
        if (beat_cnt == wgt_last) begin
          beat_n  = '0;
          state_n = S_RUN;
        end else begin
          beat_n = beat_cnt + 16'd1;
        end
      end
      S_RUN: if (run_done) state_n = S_GAP;
      S_GAP: begin
        if ({1'b0, layer} == lay_cnt - (LW+1)'(1)) begin
          state_n = S_IDLE;
          done_n  = 1'b1;
        end else begin
          layer_n = layer_inc;
          geom_n  = geom_mem[layer_inc];
          state_n = entry_state(bias_mem[layer_inc], wgt_mem[layer_inc]);
        end
      end
      default: state_n = S_IDLE;
    endcase
    // Abort wins over beats and run_done, and never advances the layer
    if (abort && (state != S_IDLE)) begin
      state_n = S_IDLE;
      layer_n = layer;
      geom_n  = geom;
      beat_n  = '0;
      done_n  = 1'b0;
    end
  end

  // Sequencer state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      layer    <= '0;
      lay_cnt  <= '0;
      beat_cnt <= '0;
      geom     <= '0;
      bwrite   <= 1'b0;
      wwrite   <= 1'b0;
      run      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all flops
      // sample pre-edge values regardless of statement order.
      state    <= state_n;
      layer    <= layer_n;
      lay_cnt  <= lay_cnt_n;
      beat_cnt <= beat_n;
      geom     <= geom_n;
      bwrite   <= (state_n == S_BIAS);
      wwrite   <= (state_n == S_WGT);
      run      <= (state_n == S_RUN);
      busy     <= (state_n != S_IDLE) || done_n;
      done     <= done_n;
    end
  end

`ifdef LAYER_SEQ_PERF_EN
  // Busy-cycle counter: cleared on start, saturating, frozen when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt <= '0;
    end else if (start_acc) begin
      cyc_cnt <= '0;
    end else if (busy && (cyc_cnt != 32'hFFFF_FFFF)) begin
      cyc_cnt <= cyc_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_layer_seq.sv
// Directed testbench for layer_seq (NL = 4). Each cycle is observed 1 ns
// after the rising edge; inputs set afterwards are sampled at the next edge.
module tb_layer_seq;

  localparam int NL = 4;
  localparam int LW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_we;
  logic [LW-1:0] cfg_layer;
  logic [1:0]    cfg_field;
  logic [31:0]   cfg_wdata;
  logic [LW:0]   num_layers;
  logic          start, abort, src_valid, src_ready, run_done;
  logic          bwrite, wwrite, run, busy, done;
  logic [LW-1:0] layer;
  logic [63:0]   geom;
`ifdef LAYER_SEQ_PERF_EN
  logic [31:0]   cyc_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] gtab [4] = '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                            64'hA5A5_0000_5A5A_FFFF, 64'h1111_2222_3333_4444};

  layer_seq #(.NL(NL)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_layer(cfg_layer),
    .cfg_field(cfg_field), .cfg_wdata(cfg_wdata), .num_layers(num_layers),
    .start(start), .abort(abort), .src_valid(src_valid), .src_ready(src_ready),
    .run_done(run_done), .bwrite(bwrite), .wwrite(wwrite), .run(run),
    .layer(layer), .geom(geom), .busy(busy), .done(done)
`ifdef LAYER_SEQ_PERF_EN
    , .cyc_cnt(cyc_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int l, input int f, input logic [31:0] d);
    cfg_we    = 1'b1;
    cfg_layer = l[LW-1:0];
    cfg_field = f[1:0];
    cfg_wdata = d;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic set_layer(input int l, input int b, input int w, input logic [63:0] g);
    cfg_write(l, 0, b);
    cfg_write(l, 1, w);
    cfg_write(l, 2, g[31:0]);
    cfg_write(l, 3, g[63:32]);
  endtask

  task automatic do_start(input int n);
    num_layers = n[LW:0];
    start      = 1'b1;
    step();
    start      = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if ({bwrite, wwrite, run, busy, done} !== 5'b0 || layer !== 2'd0 || geom !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_state: got modes/busy/done %b layer %0d geom %h, expected all zero",
               {bwrite, wwrite, run, busy, done}, layer, geom);
    end
    repeat (2) step();
    rst_n = 1'b1;
    step();
    n_checks++;
    if ({bwrite, wwrite, run, busy, done} !== 5'b0 || layer !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_release: got %b layer %0d, expected 00000 layer 0",
               {bwrite, wwrite, run, busy, done}, layer);
    end
    // Descriptors read as zero: straight to RUN with zero geometry
    do_start(1);
    n_checks++;
    if ({bwrite, wwrite, run, busy, done} !== 5'b00110 || geom !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_descriptors: got %b geom %h, expected 00110 geom 0",
               {bwrite, wwrite, run, busy, done}, geom);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  task automatic test_zero_count();
    do_start(0);
    for (int c = 1; c <= 3; c++) begin
      n_checks++;
      if ({bwrite, wwrite, run, busy, done} !== 5'b0) begin
        n_fail++;
        $display("FAIL zero_count c=%0d: got %b expected 00000", c, {bwrite, wwrite, run, busy, done});
      end
      step();
    end
  endtask

  task automatic test_two_layers();
    logic [2:0] em;
    logic [4:0] exp_v;
    int         el;
    set_layer(0, 3, 5, gtab[0]);
    set_layer(1, 0, 2, gtab[1]);
    src_valid = 1'b1;
    src_ready = 1'b1;
    do_start(2);
    for (int c = 1; c <= 18; c++) begin
      if (c <= 3)       em = 3'b100;
      else if (c <= 8)  em = 3'b010;
      else if (c <= 10) em = 3'b001;
      else if (c == 11) em = 3'b000;
      else if (c <= 13) em = 3'b010;
      else if (c <= 15) em = 3'b001;
      else              em = 3'b000;
      exp_v = {em, c <= 17, c == 17};
      el    = (c <= 11) ? 0 : 1;
      n_checks++;
      if ({bwrite, wwrite, run, busy, done} !== exp_v) begin
        n_fail++;
        $display("FAIL two_layers_modes c=%0d: got %b expected %b", c, {bwrite, wwrite, run, busy, done}, exp_v);
      end
      n_checks++;
      if (layer !== el[LW-1:0] || geom !== gtab[el]) begin
        n_fail++;
        $display("FAIL two_layers_layer c=%0d: got layer %0d geom %h expected layer %0d geom %h",
                 c, layer, geom, el, gtab[el]);
      end
      run_done = (c == 10) || (c == 15);
      step();
    end
    run_done = 1'b0;
  endtask

  task automatic test_throttle();
    logic [4:0] exp_v;
    set_layer(0, 2, 0, gtab[2]);
    src_ready = 1'b1;
    for (int rep = 0; rep < 2; rep++) begin
      src_valid = 1'b1;
      do_start(1);
      for (int c = 1; c <= 8; c++) begin
        exp_v = {c <= 4, 1'b0, c == 5, c <= 7, c == 7};
        n_checks++;
        if ({bwrite, wwrite, run, busy, done} !== exp_v) begin
          n_fail++;
          $display("FAIL throttle rep=%0d c=%0d: got %b expected %b", rep, c, {bwrite, wwrite, run, busy, done}, exp_v);
        end
        src_valid = (c % 2 == 0);
        run_done  = (c == 5);
        step();
      end
    end
    src_valid = 1'b1;
    run_done  = 1'b0;
  endtask

  task automatic test_no_loads();
    logic [4:0] exp_v;
    int         busy_cycles = 0;
    set_layer(0, 0, 0, gtab[3]);
    do_start(1);
    for (int c = 1; c <= 16; c++) begin
      exp_v = {2'b00, c <= 11, c <= 13, c == 13};
      n_checks++;
      if ({bwrite, wwrite, run, busy, done} !== exp_v) begin
        n_fail++;
        $display("FAIL no_loads c=%0d: got %b expected %b", c, {bwrite, wwrite, run, busy, done}, exp_v);
      end
      if (busy === 1'b1) busy_cycles++;
`ifdef LAYER_SEQ_PERF_EN
      if (c == 14 || c == 16) begin
        n_checks++;
        if (cyc_cnt !== 32'd13) begin
          n_fail++;
          $display("FAIL cyc_cnt_total c=%0d: got %0d expected 13", c, cyc_cnt);
        end
      end
`endif
      run_done = (c == 11);
      step();
    end
    run_done = 1'b0;
    n_checks++;
    if (busy_cycles != 13) begin
      n_fail++;
      $display("FAIL busy_span: got %0d busy cycles expected 13", busy_cycles);
    end
`ifdef LAYER_SEQ_PERF_EN
    do_start(1);
    n_checks++;
    if (cyc_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL cyc_cnt_clear: got %0d expected 0", cyc_cnt);
    end
    step();
    n_checks++;
    if (cyc_cnt !== 32'd1) begin
      n_fail++;
      $display("FAIL cyc_cnt_incr: got %0d expected 1", cyc_cnt);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
`endif
  endtask

  task automatic test_abort();
    logic [4:0] exp_v;
    set_layer(0, 1, 5, gtab[0]);
    src_valid = 1'b1;
    src_ready = 1'b1;
    do_start(2);
    for (int c = 1; c <= 4; c++) begin
      exp_v = {c == 1, c >= 2, 1'b0, 1'b1, 1'b0};
      n_checks++;
      if ({bwrite, wwrite, run, busy, done} !== exp_v) begin
        n_fail++;
        $display("FAIL abort_pre c=%0d: got %b expected %b", c, {bwrite, wwrite, run, busy, done}, exp_v);
      end
      abort = (c == 4);
      step();
    end
    abort = 1'b0;
    for (int c = 5; c <= 8; c++) begin
      n_checks++;
      if ({bwrite, wwrite, run, busy, done} !== 5'b0) begin
        n_fail++;
        $display("FAIL abort_post c=%0d: got %b expected 00000", c, {bwrite, wwrite, run, busy, done});
      end
      step();
    end
    do_start(2);
    for (int c = 1; c <= 7; c++) begin
      exp_v = {c == 1, (c >= 2) && (c <= 6), c == 7, 1'b1, 1'b0};
      n_checks++;
      if ({bwrite, wwrite, run, busy, done} !== exp_v || layer !== 2'd0) begin
        n_fail++;
        $display("FAIL abort_restart c=%0d: got %b layer %0d expected %b layer 0",
                 c, {bwrite, wwrite, run, busy, done}, layer, exp_v);
      end
      abort = (c == 7);
      step();
    end
    abort = 1'b0;
  endtask

  task automatic test_layer_cap();
    logic [4:0] exp_v;
    int         el;
    for (int l = 0; l < 4; l++) set_layer(l, 0, 0, gtab[l]);
    do_start(7);
    for (int c = 1; c <= 10; c++) begin
      exp_v = {2'b00, (c <= 8) && (c % 2 == 1), c <= 9, c == 9};
      el    = (c <= 8) ? (c - 1) / 2 : 3;
      n_checks++;
      if ({bwrite, wwrite, run, busy, done} !== exp_v) begin
        n_fail++;
        $display("FAIL layer_cap c=%0d: got %b expected %b", c, {bwrite, wwrite, run, busy, done}, exp_v);
      end
      n_checks++;
      if (layer !== el[LW-1:0] || geom !== gtab[el]) begin
        n_fail++;
        $display("FAIL layer_cap_geom c=%0d: got layer %0d geom %h expected layer %0d geom %h",
                 c, layer, geom, el, gtab[el]);
      end
      cfg_we     = (c == 2);
      cfg_layer  = 2'd2;
      cfg_field  = 2'd2;
      cfg_wdata  = 32'hDEAD_BEEF;
      start      = (c == 3);
      num_layers = (c >= 3) ? 3'd1 : 3'd7;
      run_done   = (c <= 8);
      step();
    end
    cfg_we   = 1'b0;
    start    = 1'b0;
    run_done = 1'b0;
    // run_done together with abort: straight to idle, no gap, no done
    do_start(1);
    n_checks++;
    if ({bwrite, wwrite, run, busy, done} !== 5'b00110) begin
      n_fail++;
      $display("FAIL abort_rundone_pre: got %b expected 00110", {bwrite, wwrite, run, busy, done});
    end
    run_done = 1'b1;
    abort    = 1'b1;
    step();
    run_done = 1'b0;
    abort    = 1'b0;
    for (int c = 2; c <= 3; c++) begin
      n_checks++;
      if ({bwrite, wwrite, run, busy, done} !== 5'b0) begin
        n_fail++;
        $display("FAIL abort_rundone c=%0d: got %b expected 00000", c, {bwrite, wwrite, run, busy, done});
      end
      step();
    end
  endtask

  task automatic test_async_reset();
    set_layer(0, 4, 0, gtab[1]);
    src_valid = 1'b1;
    do_start(1);
    n_checks++;
    if ({bwrite, wwrite, run, busy, done} !== 5'b10010 || geom !== gtab[1]) begin
      n_fail++;
      $display("FAIL async_reset_pre: got %b geom %h expected 10010 geom %h",
               {bwrite, wwrite, run, busy, done}, geom, gtab[1]);
    end
    step();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bwrite, wwrite, run, busy, done} !== 5'b0 || layer !== 2'd0 || geom !== 64'd0) begin
      n_fail++;
      $display("FAIL async_reset: got %b layer %0d geom %h expected all zero",
               {bwrite, wwrite, run, busy, done}, layer, geom);
    end
    #3 rst_n = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      step();
      n_checks++;
      if ({bwrite, wwrite, run, busy, done} !== 5'b0) begin
        n_fail++;
        $display("FAIL async_reset_post c=%0d: got %b expected 00000", c, {bwrite, wwrite, run, busy, done});
      end
    end
    do_start(1);
    n_checks++;
    if ({bwrite, wwrite, run, busy, done} !== 5'b00110 || geom !== 64'd0) begin
      n_fail++;
      $display("FAIL async_reset_desc: got %b geom %h expected 00110 geom 0",
               {bwrite, wwrite, run, busy, done}, geom);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    cfg_we     = 1'b0;
    cfg_layer  = '0;
    cfg_field  = '0;
    cfg_wdata  = '0;
    num_layers = '0;
    start      = 1'b0;
    abort      = 1'b0;
    src_valid  = 1'b0;
    src_ready  = 1'b0;
    run_done   = 1'b0;
    test_reset();
    test_zero_count();
    test_two_layers();
    test_throttle();
    test_no_loads();
    test_abort();
    test_layer_cap();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
